// File: rtl/sc_instr_fetch_unit.sv
// rtl/sc_instr_fetch_unit.sv - instruction fetch engine: PC owner, memory read, IR load
// Sequences IDLE->REQ->LOAD (or REQ->ABORT on missing ack) and strobes the IR with the fetched word.
module sc_instr_fetch_unit #(
    parameter int                   DATAWIDTH_BUS  = 32,
    parameter int                   ADDRWIDTH      = 32,
    parameter logic [ADDRWIDTH-1:0] RESET_PC       = '0,
    parameter int                   TIMEOUT_CYCLES = 16
) (
    input  logic                     SC_RegGENERAL_CLOCK_50,
    input  logic                     SC_RegGENERAL_RESET_InHigh,
    input  logic                     fetch_start_i,
    input  logic                     redirect_valid_i,
    input  logic [ADDRWIDTH-1:0]     redirect_addr_i,
    output logic                     mem_req_o,
    output logic [ADDRWIDTH-1:0]     mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [DATAWIDTH_BUS-1:0] mem_rdata_i,
    output logic                     ir_write_n_o,
    output logic [DATAWIDTH_BUS-1:0] ir_data_o,
    output logic [ADDRWIDTH-1:0]     pc_o,
    output logic                     busy_o,
    output logic                     fetch_done_o,
    output logic                     fetch_error_o
);

    localparam int            CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, LOAD, ABORT} state_t;

    state_t                   state_q, state_d;
    logic [ADDRWIDTH-1:0]     pc_q, pc_d;
    logic [ADDRWIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic                     mem_req_q, mem_req_d;
    logic                     ir_write_n_q, ir_write_n_d;
    logic [DATAWIDTH_BUS-1:0] ir_data_q, ir_data_d;
    logic                     fetch_done_q, fetch_done_d;
    logic                     fetch_error_q, fetch_error_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]     redirect_al;

    assign redirect_al = {redirect_addr_i[ADDRWIDTH-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_addr_d    = mem_addr_q;
        mem_req_d     = mem_req_q;
        ir_write_n_d  = 1'b1;
        ir_data_d     = ir_data_q;
        fetch_done_d  = 1'b0;
        fetch_error_d = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid_i) pc_d = redirect_al;
                if (fetch_start_i) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_valid_i ? redirect_al : pc_q;
                    cnt_d      = CW'(1);
                end
            end
            REQ: begin
                // ack is checked before the limit so a last-cycle ack still loads
                if (mem_ack_i) begin
                    state_d      = LOAD;
                    mem_req_d    = 1'b0;
                    ir_data_d    = mem_rdata_i;
                    ir_write_n_d = 1'b0;
                    fetch_done_d = 1'b1;
                end else if (cnt_q == TMO) begin
                    state_d       = ABORT;
                    mem_req_d     = 1'b0;
                    fetch_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOAD: begin
                pc_d    = mem_addr_q + ADDRWIDTH'(4);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            ir_write_n_q  <= 1'b1;
            ir_data_q     <= '0;
            fetch_done_q  <= 1'b0;
            fetch_error_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= mem_req_d;
            ir_write_n_q  <= ir_write_n_d;
            ir_data_q     <= ir_data_d;
            fetch_done_q  <= fetch_done_d;
            fetch_error_q <= fetch_error_d;
            cnt_q         <= cnt_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign ir_write_n_o  = ir_write_n_q;
    assign ir_data_o     = ir_data_q;
    assign pc_o          = pc_q;
    assign fetch_done_o  = fetch_done_q;
    assign fetch_error_o = fetch_error_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_sc_instr_fetch_unit.sv
// tb/tb_sc_instr_fetch_unit.sv - directed self-checking bench for sc_instr_fetch_unit
module tb_sc_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_start;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_write_n;
    logic [31:0] ir_data;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_done;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int n;
    int s0;

    sc_instr_fetch_unit dut (
        .SC_RegGENERAL_CLOCK_50    (clk),
        .SC_RegGENERAL_RESET_InHigh(rst),
        .fetch_start_i             (fetch_start),
        .redirect_valid_i          (redirect_valid),
        .redirect_addr_i           (redirect_addr),
        .mem_req_o                 (mem_req),
        .mem_addr_o                (mem_addr),
        .mem_ack_i                 (mem_ack),
        .mem_rdata_i               (mem_rdata),
        .ir_write_n_o              (ir_write_n),
        .ir_data_o                 (ir_data),
        .pc_o                      (pc),
        .busy_o                    (busy),
        .fetch_done_o              (fetch_done),
        .fetch_error_o             (fetch_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) if (!ir_write_n) strobes++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // fetch_start in cycle 0, ack in REQ cycle k, then check LOAD and the following IDLE
    task automatic fetch(input string tag, input logic redir, input logic [31:0] raddr,
                         input int k, input logic [31:0] data,
                         input logic [31:0] exp_addr, input logic [31:0] exp_pc);
        fetch_start = 1'b1; redirect_valid = redir; redirect_addr = raddr;
        @(negedge clk);
        fetch_start = 1'b0; redirect_valid = 1'b0;
        chk({tag, " req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, " addr"}, mem_addr, exp_addr);
        for (int i = 1; i < k; i++) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = data;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk({tag, " ir_write_n"}, {31'd0, ir_write_n}, 32'd0);
        chk({tag, " done"}, {31'd0, fetch_done}, 32'd1);
        chk({tag, " ir_data"}, ir_data, data);
        chk({tag, " req_drop"}, {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk({tag, " pc"}, pc, exp_pc);
        chk({tag, " strobe_end"}, {31'd0, ir_write_n}, 32'd1);
        chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; fetch_start = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("rst pc", pc, 32'h0);
        chk("rst req", {31'd0, mem_req}, 32'd0);
        chk("rst addr", mem_addr, 32'h0);
        chk("rst ir_write_n", {31'd0, ir_write_n}, 32'd1);
        chk("rst ir_data", ir_data, 32'h0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done_err", {30'd0, fetch_done, fetch_error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fetch("t1", 1'b0, 32'h0, 2, 32'h8A004002, 32'h0, 32'h4);
        chk("t1 strobes", strobes, 32'd1);

        redirect_valid = 1'b1; redirect_addr = 32'h00000103;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t2 redirect pc", pc, 32'h100);
        fetch("t2", 1'b0, 32'h0, 1, 32'h11112222, 32'h100, 32'h104);

        fetch("t3", 1'b1, 32'h200, 3, 32'h33334444, 32'h200, 32'h204);

        fetch("t4", 1'b1, 32'hFFFFFFFC, 1, 32'h55556666, 32'hFFFFFFFC, 32'h0);

        s0 = strobes;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        n = 1;
        while (!fetch_error && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5 timeout cycle", n, 32'd17);
        chk("t5 err", {31'd0, fetch_error}, 32'd1);
        chk("t5 req", {31'd0, mem_req}, 32'd0);
        chk("t5 ir_write_n", {31'd0, ir_write_n}, 32'd1);
        @(negedge clk);
        chk("t5 err pulse", {31'd0, fetch_error}, 32'd0);
        chk("t5 pc", pc, 32'h0);
        chk("t5 ir_data held", ir_data, 32'h55556666);
        chk("t5 no strobe", strobes, s0);
        chk("t5 idle", {31'd0, busy}, 32'd0);

        fetch("t5b", 1'b1, 32'h40, 16, 32'h77778888, 32'h40, 32'h44);

        s0 = strobes;
        fetch_start = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h80;
        @(negedge clk);
        fetch_start = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6 req before rst", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6 req async drop", {31'd0, mem_req}, 32'd0);
        chk("t6 pc", pc, 32'h0);
        chk("t6 busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t6 no strobe", strobes, s0);
        chk("t6 ir_data reset", ir_data, 32'h0);

        s0 = strobes;
        fetch_start = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h500;
        @(negedge clk);
        fetch_start = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        fetch_start = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h300;
        @(negedge clk);
        fetch_start = 1'b0; redirect_valid = 1'b0;
        chk("t7 addr stable", mem_addr, 32'h500);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t7 ir_data", ir_data, 32'hCAFEF00D);
        @(negedge clk);
        chk("t7 pc", pc, 32'h504);
        repeat (3) @(negedge clk);
        chk("t7 no second fetch", {30'd0, busy, mem_req}, 32'd0);
        chk("t7 single strobe", strobes, s0 + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
